// File: rtl/freq_meter.sv
// freq_meter: measures the rising-to-rising interval of an asynchronous
// divided clock in clk cycles, classifies it as one of the ratios
// 2/4/8/16 (within +/-TOL) and reports lock after LOCK_N identical results.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   en           in   measurement enable
//   sig_in       in   asynchronous signal under measurement
//   period       out  last measured interval (CNT_W bits)
//   period_valid out  one-cycle pulse when period updates
//   sel_det      out  decoded divide select of the last valid measurement
//   sel_valid    out  last measurement matched a defined ratio
//   locked       out  LOCK_N consecutive identical sel_det results
//   timeout      out  one-cycle pulse when the counter saturates
module freq_meter #(
    parameter int CNT_W  = 16,
    parameter int LOCK_N = 4,
    parameter int TOL    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [1:0]       sel_det,
    output logic             sel_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int MW = $clog2(LOCK_N + 1);
    localparam logic [MW-1:0] LOCK_V = MW'(LOCK_N);

    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    state_t           state;
    logic             sync1, sync2, prev;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic [MW-1:0]    match_cnt;
    logic [MW-1:0]    match_nxt;
    logic             hit;
    logic [1:0]       hit_k;

    // two synchronizer flops then one history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

    // classify the running count (the value captured on a rise);
    // k is scanned downward so the lowest matching ratio wins
    always_comb begin
        logic [63:0] p64, tgt, lo, hi;
        hit   = 1'b0;
        hit_k = 2'd0;
        p64   = 64'(cnt);
        for (int k = 3; k >= 0; k--) begin
            tgt = 64'd2 << k;
            lo  = (tgt > 64'(TOL)) ? tgt - 64'(TOL) : 64'd0;
            hi  = tgt + 64'(TOL);
            if (p64 >= lo && p64 <= hi) begin
                hit   = 1'b1;
                hit_k = 2'(k);
            end
        end
    end

    // next match count when the new result is a valid classification
    always_comb begin
        match_nxt = 1;
        if (sel_valid && hit_k == sel_det)
            match_nxt = (match_cnt == LOCK_V) ? LOCK_V : match_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            match_cnt    <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            sel_det      <= 2'd0;
            sel_valid    <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            if (!en) begin
                // results are held; only the measurement state is dropped
                state     <= IDLE;
                cnt       <= '0;
                match_cnt <= '0;
                locked    <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= ARM;
                    ARM: begin
                        if (rise) begin
                            cnt   <= CNT_W'(1);
                            state <= MEAS;
                        end
                    end
                    MEAS: begin
                        // a rise takes priority over saturation, so an
                        // all-ones interval is still a valid period
                        if (rise) begin
                            period       <= cnt;
                            cnt          <= CNT_W'(1);
                            period_valid <= 1'b1;
                            if (hit) begin
                                sel_det   <= hit_k;
                                sel_valid <= 1'b1;
                                match_cnt <= match_nxt;
                                locked    <= (match_nxt == LOCK_V);
                            end else begin
                                sel_valid <= 1'b0;
                                match_cnt <= '0;
                                locked    <= 1'b0;
                            end
                        end else if (&cnt) begin
                            timeout   <= 1'b1;
                            cnt       <= '0;
                            match_cnt <= '0;
                            locked    <= 1'b0;
                            state     <= ARM;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: two instances (TOL=0 and TOL=2) share
// the stimulus; expected results are queued per instance and a monitor
// pops one entry per period_valid/timeout pulse.
module tb_freq_meter;

    localparam int CW = 8;

    typedef struct {
        bit to;
        int per;
        int sel;
        bit sv;
        bit lk;
    } exp_t;

    logic clk = 1'b0;
    logic rst, en, sig;
    logic [CW-1:0] per0, per1;
    logic pv0, pv1, sv0, sv1, lk0, lk1, to0, to1;
    logic [1:0] sd0, sd1;

    int total = 0;
    int bad   = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    freq_meter #(.CNT_W(CW), .LOCK_N(4), .TOL(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig),
        .period(per0), .period_valid(pv0), .sel_det(sd0),
        .sel_valid(sv0), .locked(lk0), .timeout(to0));

    freq_meter #(.CNT_W(CW), .LOCK_N(4), .TOL(2)) dut1 (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig),
        .period(per1), .period_valid(pv1), .sel_det(sd1),
        .sel_valid(sv1), .locked(lk1), .timeout(to1));

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // push n identical expectations for instance d
    task automatic e(input int d, input bit to, input int per, input int sel,
                     input bit sv, input bit lk, input int n);
        exp_t x;
        x.to = to; x.per = per; x.sel = sel; x.sv = sv; x.lk = lk;
        for (int i = 0; i < n; i++) begin
            if (d == 0) q0.push_back(x);
            else        q1.push_back(x);
        end
    endtask

    // n segments, each starting with a rise and lasting p cycles
    task automatic seg(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            sig = 1'b1;
            repeat (p / 2) @(posedge clk);
            #1 sig = 1'b0;
            repeat (p - p / 2) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // monitor: one scoreboard pop per output pulse
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic pv, to, sv, lk;
            int per, sel;
            exp_t x;
            pv  = (d == 0) ? pv0 : pv1;
            to  = (d == 0) ? to0 : to1;
            sv  = (d == 0) ? sv0 : sv1;
            lk  = (d == 0) ? lk0 : lk1;
            per = (d == 0) ? int'(per0) : int'(per1);
            sel = (d == 0) ? int'(sd0) : int'(sd1);
            if (pv && to) begin
                total++; bad++;
                $display("FAIL dut%0d pulse_overlap: period_valid and timeout both 1", d);
            end else if (pv || to) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    total++; bad++;
                    $display("FAIL dut%0d unexpected_pulse: pv=%0d to=%0d period=%0d", d, pv, to, per);
                end else begin
                    x = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("dut%0d pulse_kind", d), int'(to), int'(x.to));
                    chk($sformatf("dut%0d period", d), per, x.per);
                    chk($sformatf("dut%0d locked", d), int'(lk), int'(x.lk));
                    if (!x.to) begin
                        chk($sformatf("dut%0d sel_det", d), sel, x.sel);
                        chk($sformatf("dut%0d sel_valid", d), int'(sv), int'(x.sv));
                    end
                end
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, " period0"}, int'(per0), 0);
        chk({tag, " period1"}, int'(per1), 0);
        chk({tag, " pv"}, int'(pv0) + int'(pv1), 0);
        chk({tag, " to"}, int'(to0) + int'(to1), 0);
        chk({tag, " sel_det"}, int'(sd0) + int'(sd1), 0);
        chk({tag, " sel_valid"}, int'(sv0) + int'(sv1), 0);
        chk({tag, " locked"}, int'(lk0) + int'(lk1), 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; sig = 1'b0;
        idle(3);
        chk_zero("reset");
        rst = 1'b0;
        idle(3);

        // ratio sweep 4,8,2,16 then unmatched 6, ending in a timeout
        e(0, 0, 4, 1, 1, 0, 3);  e(0, 0, 4, 1, 1, 1, 2);
        e(0, 0, 8, 2, 1, 0, 3);  e(0, 0, 8, 2, 1, 1, 2);
        e(0, 0, 2, 0, 1, 0, 3);  e(0, 0, 2, 0, 1, 1, 2);
        e(0, 0, 16, 3, 1, 0, 2);
        e(0, 0, 6, 3, 0, 0, 2);
        e(0, 1, 6, 0, 0, 0, 1);
        // TOL=2: 4 falls in 2+/-2 first, 6 in 4+/-2 before 8+/-2
        e(1, 0, 4, 0, 1, 0, 3);  e(1, 0, 4, 0, 1, 1, 2);
        e(1, 0, 8, 2, 1, 0, 3);  e(1, 0, 8, 2, 1, 1, 2);
        e(1, 0, 2, 0, 1, 0, 3);  e(1, 0, 2, 0, 1, 1, 2);
        e(1, 0, 16, 3, 1, 0, 2);
        e(1, 0, 6, 1, 1, 0, 2);
        e(1, 1, 6, 0, 0, 0, 1);
        seg(4, 5); seg(8, 5); seg(2, 5); seg(16, 2); seg(6, 3);
        idle(300);

        // after timeout: re-arm, then an all-ones interval ends on a rise
        e(0, 0, 4, 1, 1, 0, 1);  e(0, 0, 255, 1, 0, 0, 1);
        e(1, 0, 4, 0, 1, 0, 1);  e(1, 0, 255, 0, 0, 0, 1);
        seg(4, 1); seg(255, 1); seg(4, 1);

        // enable dropped mid-measurement: held results, no pulses
        en = 1'b0;
        seg(4, 3);
        idle(4);
        chk("en0 period0", int'(per0), 255);
        chk("en0 period1", int'(per1), 255);
        chk("en0 locked", int'(lk0) + int'(lk1), 0);
        en = 1'b1;
        idle(4);
        e(0, 0, 8, 2, 1, 0, 2);
        e(1, 0, 8, 2, 1, 0, 2);
        seg(8, 3);

        // reset mid-measurement: outputs cleared, two fresh rises needed
        rst = 1'b1;
        idle(1);
        chk_zero("midrst");
        rst = 1'b0;
        idle(5);
        e(0, 0, 4, 1, 1, 0, 2);  e(0, 1, 4, 0, 0, 0, 1);
        e(1, 0, 4, 0, 1, 0, 2);  e(1, 1, 4, 0, 0, 0, 1);
        seg(4, 3);
        idle(300);

        chk("q0 drained", q0.size(), 0);
        chk("q1 drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter CNT_W, default 16: width of the period counter and the period output.
REQ-002 Parameter LOCK_N, default 4: number of consecutive identical classifications required to assert locked.
REQ-003 Parameter TOL, default 0: ± tolerance in clk cycles used when classifying a period.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 en  input  1  measurement enable.
REQ-007 sig_in  input  1  asynchronous divided-clock signal under measurement.
REQ-008 period  output  CNT_W  last measured rising-to-rising interval, in clk cycles.
REQ-009 period_valid  output  1  one-cycle pulse when period updates.
REQ-010 sel_det  output  2  decoded divide select of the last valid measurement.
REQ-011 sel_valid  output  1  high when the last measurement matched a defined ratio.
REQ-012 locked  output  1  high after LOCK_N consecutive identical sel_det results.
REQ-013 timeout  output  1  one-cycle pulse when the counter saturates without seeing an edge.

Function
REQ-014 sig_in SHALL pass through a 2-flop synchronizer, then a third register for edge detection; rise = sync & ~prev.
REQ-015 A rising edge of sig_in sampled at clk edge k SHALL produce rise in cycle k+2.
REQ-016 The FSM SHALL have three states.
- IDLE: entered when en=0; leaves to ARM when en=1.
- ARM: waits for the first rise.
- MEAS: counts cycles between rises.
REQ-017 In ARM, on rise: cnt <= 1 and the FSM moves to MEAS; no period_valid is issued.
REQ-018 In MEAS, each cycle without rise: cnt <= cnt+1.
REQ-019 In MEAS, on rise, the block SHALL:
- capture period <= cnt;
- set cnt <= 1;
- pulse period_valid in the following cycle, with period and sel_det already updated in that cycle.
REQ-020 Saturation: if cnt = all-ones in MEAS without rise, the block SHALL:
- pulse timeout in the next cycle;
- leave period unchanged;
- clear locked and the match count;
- return to ARM.
REQ-021 Simultaneous rise and saturation SHALL be treated as rise, with period = all-ones and no timeout.
REQ-022 Classification SHALL map period P to sel_det = k (k=0..3) when |P − 2^(k+1)| <= TOL, i.e. 2→00, 4→01, 8→10, 16→11.
- On overlapping ranges the lowest k wins.
- No match: sel_valid=0 and sel_det holds its previous value.
REQ-023 The match count SHALL update on each period_valid:
- sel_valid=0: count <= 0 and locked <= 0.
- sel_det equals the previous valid sel_det: count increments, saturating at LOCK_N.
- Otherwise: count <= 1 and locked <= 0.
- locked SHALL be 1 whenever count = LOCK_N, in the same cycle as the qualifying period_valid.
REQ-024 en deasserted in any state SHALL, in the next cycle:
- move the FSM to IDLE;
- clear cnt, count and locked;
- suppress pulses;
- hold period, sel_det and sel_valid.
REQ-025 Pulses period_valid and timeout SHALL never be high in the same cycle.

Reset
REQ-026 While rst=1 at a clk edge, the block SHALL:
- set period=0, sel_det=0, sel_valid=0, locked=0, period_valid=0, timeout=0;
- clear the synchronizer flops, cnt and count;
- put the FSM in IDLE.
REQ-027 Reset asserted mid-measurement SHALL discard the partial count; the first period_valid after reset requires two fresh rises.
REQ-028 After rst deasserts with en=1, the FSM SHALL enter ARM on the next cycle.

Verification
REQ-029 Scenario 1: en=1, sig_in square wave of period 4 clk (2 high, 2 low) -> first period_valid 3 cycles after the second sampled rise, with period=4, sel_det=01, sel_valid=1; locked=1 on the 4th period_valid.
REQ-030 Scenario 2: period 8 until locked (sel_det=10), then switch to period 2 -> locked=0 on the first period_valid showing period=2, sel_det=00; locked=1 again on the 4th consecutive period=2 result.
REQ-031 Scenario 3: period 6, TOL=0 -> period=6, sel_valid=0, sel_det holds its prior value, locked stays 0; with TOL=2, period 6 classifies as sel_det=01 (4±2 wins over 8±2).
REQ-032 Scenario 4: after lock, hold sig_in low for 2^CNT_W cycles -> a single timeout pulse, locked=0, period unchanged; the next two rises yield a new period_valid.
REQ-033 Scenario 5: rst=1 for one cycle mid-MEAS, and separately en=0 mid-MEAS ->
- rst: all outputs 0 on the next cycle;
- en=0: FSM in IDLE, period held, no pulses until two rises after en returns to 1.
